aes_iter_core: RTL and testbench

- Iterative AES encryption engine; one round is computed per clock, replacing the fully unrolled 10-round combinational encryptor.
- Parametrised for AES-128 or AES-256; the key schedule is expanded on the fly, one round key per cycle.
- An optional post-cipher Caesar layer, using the existing caeser_lyr, is applied with the final round key.
- Sits between a plaintext/key producer and a ciphertext consumer, with valid/ready handshakes on both sides.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_key_step.sv | 51 +++++
 rtl/aes_round_ops.sv | 54 +++++
 rtl/aes_iter_core.sv | 122 ++++++++++++
 tb/tb_aes_iter_core.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round counts, core states and the GF(2^8) helpers
// used by both the datapath S-boxes and the key schedule.
package aes_pkg;

  localparam int NR_128 = 10;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational next-round-key generator; AES-128 or AES-256 schedule chosen
// by KEY_BITS. Word 0 of every 128-bit key register sits in bits [127:96].
module aes_key_step
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic [127:0] ka,
  input  logic [127:0] kb,
  input  logic [7:0]   rcon,
  input  logic [3:0]   rnd,
  output logic [127:0] round_key,
  output logic [127:0] ka_next,
  output logic [127:0] kb_next,
  output logic         rcon_adv
);

  logic [31:0] last_w;
  logic [31:0] t;
  logic [31:0] w0, w1, w2, w3;
  logic        use_rot;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    last_w    = (KEY_BITS == 256) ? kb[31:0] : ka[31:0];
    use_rot   = (KEY_BITS == 256) ? ~rnd[0] : 1'b1;
    t         = use_rot ? (sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon, 24'h000000})
                        : sub_word(last_w);
    w0        = ka[127:96] ^ t;
    w1        = ka[95:64]  ^ w0;
    w2        = ka[63:32]  ^ w1;
    w3        = ka[31:0]   ^ w2;
    round_key = {w0, w1, w2, w3};
    ka_next   = {w0, w1, w2, w3};
    kb_next   = kb;
    rcon_adv  = 1'b1;
    if (KEY_BITS == 256) begin
      // Round 1 of AES-256 is the second half of the cipher key itself.
      if (rnd == 4'd1) begin
        round_key = kb;
        ka_next   = ka;
        rcon_adv  = 1'b0;
      end else begin
        ka_next   = kb;
        kb_next   = {w0, w1, w2, w3};
        rcon_adv  = use_rot;
      end
    end
  end

endmodule

// File: rtl/aes_round_ops.sv
// AES round primitives (SubBytes, ShiftRows, MixColumns) and the post-cipher
// Caesar layer. Byte n of a block sits in bits [127-8n -: 8], column-major.
module sub_byte
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  always_comb begin
    for (int i = 0; i < 16; i++) dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end
endmodule

module shift_row (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  always_comb begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
  end
endmodule

module mix_col
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  function automatic logic [31:0] mix_one(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    for (int c = 0; c < 4; c++) dout[127-32*c -: 32] = mix_one(din[127-32*c -: 32]);
  end
endmodule

// Byte-wise modular addition of the round key: a Caesar shift per byte.
module caeser_lyr (
  input  logic [127:0] data_in,
  input  logic [127:0] round_key,
  output logic [127:0] ark_out
);
  always_comb begin
    for (int i = 0; i < 16; i++) ark_out[8*i +: 8] = data_in[8*i +: 8] + round_key[8*i +: 8];
  end
endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryptor: one round per clock, on-the-fly key schedule,
// optional Caesar post-layer, valid/ready on both sides.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS  = 128,
  parameter bit CAESAR_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plaintext,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        cyphertext,
  output logic                busy
);

  localparam int         NR   = (KEY_BITS == 256) ? NR_256 : NR_128;
  localparam logic [3:0] NR_L = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] ka_q, ka_d;
  logic [127:0] kb_q, kb_d;
  logic [127:0] cyph_q, cyph_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [127:0] round_key, ka_next, kb_next;
  logic         rcon_adv;
  logic [127:0] sb_out, sr_out, mc_out, round_out, final_out;

  aes_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
    .ka(ka_q), .kb(kb_q), .rcon(rcon_q), .rnd(rnd_q),
    .round_key(round_key), .ka_next(ka_next), .kb_next(kb_next), .rcon_adv(rcon_adv)
  );

  sub_byte  u_sub_byte  (.din(st_q),   .dout(sb_out));
  shift_row u_shift_row (.din(sb_out), .dout(sr_out));
  mix_col   u_mix_col   (.din(sr_out), .dout(mc_out));

  // The final round skips MixColumns.
  assign round_out = ((rnd_q == NR_L) ? sr_out : mc_out) ^ round_key;

  if (CAESAR_EN) begin : g_caesar
    caeser_lyr u_caeser_lyr (.data_in(round_out), .round_key(round_key), .ark_out(final_out));
  end else begin : g_no_caesar
    assign final_out = round_out;
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    cyph_d  = cyph_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = plaintext ^ key[KEY_BITS-1 -: 128];
          ka_d    = key[KEY_BITS-1 -: 128];
          kb_d    = key[127:0];
          rnd_d   = 4'd1;
          rcon_d  = 8'h01;
          state_d = RUN;
        end
      end
      RUN: begin
        st_d  = round_out;
        ka_d  = ka_next;
        kb_d  = kb_next;
        rnd_d = rnd_q + 4'd1;
        if (rcon_adv) rcon_d = xtime(rcon_q);
        if (rnd_q == NR_L) begin
          cyph_d  = final_out;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the key and state registers are cleared too, so an abandoned block leaves no key material behind.
      state_q <= IDLE;
      st_q    <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      cyph_q  <= '0;
      rnd_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q <= state_d;
      st_q    <= st_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      cyph_q  <= cyph_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign out_valid  = (state_q == DONE);
  assign cyphertext = cyph_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: three instances (AES-128, AES-256, AES-128+Caesar)
// checked against a full-key-expansion reference model and FIPS-197 vectors.
module tb_aes_iter_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv[3], ir[3], ov[3], ordy[3], bz[3];
  logic [127:0] pt[3], ct[3];
  logic [255:0] ky[3];
  logic [7:0]   sb[256];
  int           n_checks = 0;
  int           n_err    = 0;

  always #5 clk = ~clk;

  aes_iter_core #(.KEY_BITS(128), .CAESAR_EN(1'b0)) u_a128 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .plaintext(pt[0]),
    .key(ky[0][127:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .cyphertext(ct[0]), .busy(bz[0]));
  aes_iter_core #(.KEY_BITS(256), .CAESAR_EN(1'b0)) u_a256 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .plaintext(pt[1]),
    .key(ky[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .cyphertext(ct[1]), .busy(bz[1]));
  aes_iter_core #(.KEY_BITS(128), .CAESAR_EN(1'b1)) u_a128c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .plaintext(pt[2]),
    .key(ky[2][127:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .cyphertext(ct[2]), .busy(bz[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] m2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from the generator-3 / inverse-3 walk over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] caesar_add(input logic [127:0] d, input logic [127:0] k);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = d[8*n +: 8] + k[8*n +: 8];
    return r;
  endfunction

  function automatic logic [127:0] ref_aes(input logic [127:0] p, input logic [255:0] k,
                                           input int kbits, input bit caesar);
    logic [31:0]  w[60];
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    logic [127:0] rk;
    int nk, nr;
    nk = kbits / 32;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[32*(nk-1-i) +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = m2(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int n = 0; n < 16; n++) s[n] = sb[s[n]];
      for (int n = 0; n < 16; n++) t[n] = s[(n%4) + 4*(((n/4) + (n%4)) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (r < nr) begin
          s[4*c]   = m2(t[4*c]) ^ m2(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ m2(t[4*c+1]) ^ m2(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ m2(t[4*c+2]) ^ m2(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = m2(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ m2(t[4*c+3]);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    rk = {w[4*nr], w[4*nr+1], w[4*nr+2], w[4*nr+3]};
    return caesar ? caesar_add(res, rk) : res;
  endfunction

  function automatic int kbits_of(input int idx);
    return (idx == 1) ? 256 : 128;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends one block, measures latency, optionally holds out_ready low for
  // `hold` cycles (with a stray in_valid pulse), then completes the handshake.
  task automatic run_block(input int idx, input logic [127:0] p, input logic [255:0] k,
                           input int hold, input string tag);
    logic [127:0] exp, saw;
    int lat, bad, extra, nr;
    exp = ref_aes(p, k, kbits_of(idx), idx == 2);
    nr  = kbits_of(idx) / 32 + 6;
    check({tag, " in_ready idle"}, 128'(ir[idx]), 128'(1));
    pt[idx] = p;
    ky[idx] = k;
    iv[idx] = 1'b1;
    @(negedge clk);
    iv[idx] = 1'b0;
    pt[idx] = rand128();
    ky[idx] = {rand128(), rand128()};
    check({tag, " busy/in_ready in RUN"}, {126'd0, bz[idx], ir[idx]}, 128'b10);
    lat = 0;
    while (!ov[idx] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(nr));
    check({tag, " cyphertext"}, ct[idx], exp);
    if (hold > 0) begin
      bad = 0;
      saw = ct[idx];
      for (int i = 0; i < hold; i++) begin
        if (i == hold / 2) begin
          pt[idx] = rand128();
          iv[idx] = 1'b1;
        end else begin
          iv[idx] = 1'b0;
        end
        @(negedge clk);
        if (ct[idx] !== saw || ir[idx] !== 1'b0 || ov[idx] !== 1'b1) bad++;
      end
      iv[idx] = 1'b0;
      check({tag, " backpressure stable cycles bad"}, 128'(bad), 128'd0);
    end
    ordy[idx] = 1'b1;
    @(negedge clk);
    ordy[idx] = 1'b0;
    check({tag, " after handshake ov/ir"}, {126'd0, ov[idx], ir[idx]}, 128'b01);
    if (hold > 0) begin
      extra = 0;
      repeat (16) begin
        @(negedge clk);
        if (ov[idx] !== 1'b0 || bz[idx] !== 1'b0) extra++;
      end
      check({tag, " no second result"}, 128'(extra), 128'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] fips_pt, p, exp_c;
    logic [255:0] k;
    logic [127:0] exp_q[$];
    int t_out[$];
    int sent, got;

    build_sbox();
    fips_pt = 128'h00112233445566778899aabbccddeeff;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; pt[i] = '0; ky[i] = '0;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset inst%0d ir/ov/busy", i), {125'd0, ir[i], ov[i], bz[i]}, 128'b100);
    check("reset cyphertext", ct[0], 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 AES-128 and AES-256 vectors
    run_block(0, fips_pt, {128'd0, 128'h000102030405060708090a0b0c0d0e0f}, 0, "fips128");
    check("fips128 known answer", ct[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run_block(1, fips_pt, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              0, "fips256");
    check("fips256 known answer", ct[1], 128'h8ea2b7ca516745bfeafc49904b496089);

    // Random vectors on both key sizes
    for (int j = 0; j < 3; j++) begin
      run_block(0, rand128(), {128'd0, rand128()}, 0, $sformatf("rand128_%0d", j));
      run_block(1, rand128(), {rand128(), rand128()}, 0, $sformatf("rand256_%0d", j));
    end

    // Backpressure with a stray in_valid pulse during DONE
    run_block(0, rand128(), {128'd0, rand128()}, 20, "backpressure");

    // Reset in the middle of round 5
    pt[0] = rand128();
    ky[0] = {128'd0, rand128()};
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset ir/ov/busy", {125'd0, ir[0], ov[0], bz[0]}, 128'b100);
    check("midreset cyphertext", ct[0], 128'd0);
    run_block(0, fips_pt, {128'd0, 128'h000102030405060708090a0b0c0d0e0f}, 0, "post_reset");
    check("post_reset known answer", ct[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Caesar layer
    run_block(2, fips_pt, {128'd0, 128'h000102030405060708090a0b0c0d0e0f}, 0, "caesar_fips");
    exp_c = caesar_add(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("caesar standalone", ct[2], exp_c);
    run_block(2, rand128(), {128'd0, rand128()}, 0, "caesar_rand");

    // Streaming: three blocks, out_ready held high, in_valid kept high with junk when not idle
    ordy[0] = 1'b1;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 100 && got < 3; c++) begin
      if (ov[0]) begin
        if (exp_q.size() > 0) check($sformatf("stream result %0d", got), ct[0], exp_q.pop_front());
        t_out.push_back(c);
        got++;
      end
      if (ir[0] && sent < 3) begin
        p = rand128();
        k = {128'd0, rand128()};
        pt[0] = p;
        ky[0] = k;
        exp_q.push_back(ref_aes(p, k, 128, 1'b0));
        iv[0] = 1'b1;
        sent++;
      end else if (ir[0]) begin
        iv[0] = 1'b0;
      end else begin
        pt[0] = rand128();
        iv[0] = 1'b1;
      end
      @(negedge clk);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b0;
    check("stream result count", 128'(got), 128'd3);
    if (t_out.size() == 3) begin
      check("stream spacing 1", 128'(t_out[1] - t_out[0]), 128'd12);
      check("stream spacing 2", 128'(t_out[2] - t_out[1]), 128'd12);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
